// File: rtl/twiddle_angle_gen_pkg.sv
// Shared definitions for the twiddle angle sequencer: FSM state type,
// angle word width and the per-index angle increment.
package twiddle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int ANGLE_W = 32;

  // One full turn is 2^ANGLE_W, so index k of an N-point FFT sits at k * 2^(ANGLE_W-LOG2N).
  function automatic logic [ANGLE_W-1:0] angle_step(input int log2n);
    return {{(ANGLE_W-1){1'b0}}, 1'b1} << (ANGLE_W - log2n);
  endfunction

endpackage

// File: rtl/twiddle_angle_gen_tag_delay.sv
// Tag shift register matching the CORDIC core latency; async active-low clear
// flushes every stage so stale entries never report as valid.
module tag_delay #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  logic [W-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/twiddle_angle_gen.sv
// Twiddle angle sequencer feeding a CORDIC sin/cos core, with a latency-matched
// tag line. Define TWIDDLE_HALF_EN to emit only the first N/2 twiddles.
module twiddle_angle_gen
  import twiddle_pkg::*;
#(
  parameter int                      LOG2N      = 6,
  parameter int                      WIDTH      = 16,
  parameter int                      CORDIC_LAT = 16,
  parameter logic signed [WIDTH-1:0] AMP        = 16'sh7FFF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 inverse,
  output logic                 busy,
  output logic                 done,
  output logic [ANGLE_W-1:0]   angle,
  output logic [WIDTH-1:0]     x_start,
  output logic [WIDTH-1:0]     y_start,
  output logic                 ang_valid,
  output logic                 tw_valid,
  output logic [LOG2N-1:0]     tw_index,
  output logic                 tw_last
);

  localparam int TAG_W = LOG2N + 2;
  localparam logic [ANGLE_W-1:0] STEP = angle_step(LOG2N);
`ifdef TWIDDLE_HALF_EN
  localparam logic [LOG2N-1:0] KMAX = {1'b0, {(LOG2N-1){1'b1}}};
`else
  localparam logic [LOG2N-1:0] KMAX = {LOG2N{1'b1}};
`endif

  function automatic logic [ANGLE_W-1:0] angle_of(input logic [LOG2N-1:0] k, input logic inv);
    logic [ANGLE_W-1:0] mag;
    mag = ANGLE_W'(k) * STEP;
    return inv ? mag : (~mag + 1'b1);
  endfunction

  state_e               state_q;
  logic                 inv_q;
  logic                 busy_q;
  logic                 av_q;
  logic [LOG2N-1:0]     k_q;
  logic [ANGLE_W-1:0]   angle_q;
  logic [WIDTH-1:0]     x_q;

  logic [LOG2N-1:0]     k_d;
  logic [ANGLE_W-1:0]   angle_d;
  logic                 last_in;
  logic [TAG_W-1:0]     tag_in;
  logic [TAG_W-1:0]     tag_out;

  assign k_d     = k_q + 1'b1;
  assign angle_d = angle_of(k_d, inv_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      av_q    <= 1'b0;
      k_q     <= '0;
      angle_q <= '0;
      x_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            inv_q   <= inverse;
            busy_q  <= 1'b1;
            av_q    <= 1'b1;
            k_q     <= '0;
            angle_q <= '0;
            x_q     <= AMP;
          end
        end
        RUN: begin
          if (k_q == KMAX) begin
            state_q <= DRAIN;
            av_q    <= 1'b0;
            k_q     <= '0;
            angle_q <= '0;
            x_q     <= '0;
          end else begin
            k_q     <= k_d;
            angle_q <= angle_d;
          end
        end
        DRAIN: begin
          // The final tag reaching the output is the done cycle; leave on its closing edge.
          if (tag_out[0]) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign last_in = av_q && (k_q == KMAX);
  assign tag_in  = {av_q, (av_q ? k_q : {LOG2N{1'b0}}), last_in};

  tag_delay #(
    .DEPTH (CORDIC_LAT),
    .W     (TAG_W)
  ) u_tag_delay (
    .clk_i   (clock),
    .rst_n_i (reset_n),
    .din_i   (tag_in),
    .dout_o  (tag_out)
  );

  assign busy      = busy_q;
  assign ang_valid = av_q;
  assign angle     = angle_q;
  assign x_start   = x_q;
  assign y_start   = '0;
  assign tw_valid  = tag_out[TAG_W-1];
  assign tw_index  = tag_out[TAG_W-2:1];
  assign tw_last   = tag_out[0];
  assign done      = tag_out[0];

endmodule

// File: tb/tb_twiddle_angle_gen.sv
// Directed bench for twiddle_angle_gen at LOG2N=3, CORDIC_LAT=16.
module tb_twiddle_angle_gen;

  localparam int LOG2N = 3;
  localparam int LAT   = 16;
`ifdef TWIDDLE_HALF_EN
  localparam int KMAX  = 3;
`else
  localparam int KMAX  = 7;
`endif

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        inverse;
  logic        busy;
  logic        done;
  logic [31:0] angle;
  logic [15:0] x_start;
  logic [15:0] y_start;
  logic        ang_valid;
  logic        tw_valid;
  logic [LOG2N-1:0] tw_index;
  logic        tw_last;

  int checks = 0;
  int errors = 0;

  logic [31:0] fwd_tab [8] = '{32'h00000000, 32'hE0000000, 32'hC0000000, 32'hA0000000,
                               32'h80000000, 32'h60000000, 32'h40000000, 32'h20000000};
  logic [31:0] inv_tab [8] = '{32'h00000000, 32'h20000000, 32'h40000000, 32'h60000000,
                               32'h80000000, 32'hA0000000, 32'hC0000000, 32'hE0000000};

  twiddle_angle_gen #(
    .LOG2N      (LOG2N),
    .WIDTH      (16),
    .CORDIC_LAT (LAT),
    .AMP        (16'sh7FFF)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .inverse   (inverse),
    .busy      (busy),
    .done      (done),
    .angle     (angle),
    .x_start   (x_start),
    .y_start   (y_start),
    .ang_valid (ang_valid),
    .tw_valid  (tw_valid),
    .tw_index  (tw_index),
    .tw_last   (tw_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " done"},      32'(done),      32'd0);
    chk({tag, " angle"},     angle,          32'd0);
    chk({tag, " x_start"},   32'(x_start),   32'd0);
    chk({tag, " y_start"},   32'(y_start),   32'd0);
    chk({tag, " ang_valid"}, 32'(ang_valid), 32'd0);
    chk({tag, " tw_valid"},  32'(tw_valid),  32'd0);
    chk({tag, " tw_index"},  32'(tw_index),  32'd0);
    chk({tag, " tw_last"},   32'(tw_last),   32'd0);
  endtask

  // Start a sequence in the current cycle and check every cycle through the done cycle.
  task automatic run_seq(input string tag, input bit inv, input bit inject);
    int last_c;
    int ndone;
    bit av;
    bit tv;
    logic [31:0] ea;
    last_c = KMAX + 1 + LAT;
    ndone  = 0;
    start   = 1'b1;
    inverse = inv;
    step();
    start   = 1'b0;
    inverse = ~inv;
    for (int c = 1; c <= last_c; c++) begin
      av = (c <= KMAX + 1);
      tv = (c >= LAT + 1);
      ea = av ? (inv ? inv_tab[c-1] : fwd_tab[c-1]) : 32'd0;
      chk($sformatf("%s c%0d angle", tag, c),     angle,          ea);
      chk($sformatf("%s c%0d ang_valid", tag, c), 32'(ang_valid), 32'(av));
      chk($sformatf("%s c%0d x_start", tag, c),   32'(x_start),   av ? 32'h7FFF : 32'd0);
      chk($sformatf("%s c%0d y_start", tag, c),   32'(y_start),   32'd0);
      chk($sformatf("%s c%0d busy", tag, c),      32'(busy),      32'd1);
      chk($sformatf("%s c%0d tw_valid", tag, c),  32'(tw_valid),  32'(tv));
      chk($sformatf("%s c%0d tw_index", tag, c),  32'(tw_index),  tv ? 32'(c - 1 - LAT) : 32'd0);
      chk($sformatf("%s c%0d tw_last", tag, c),   32'(tw_last),   32'(c == last_c));
      chk($sformatf("%s c%0d done", tag, c),      32'(done),      32'(c == last_c));
      if (done) ndone++;
      start = inject && (c == 5 || c == last_c);
      step();
    end
    start = 1'b0;
    chk({tag, " after busy"},      32'(busy),      32'd0);
    chk({tag, " after done"},      32'(done),      32'd0);
    chk({tag, " after ang_valid"}, 32'(ang_valid), 32'd0);
    chk({tag, " after tw_valid"},  32'(tw_valid),  32'd0);
    chk({tag, " done count"},      32'(ndone),     32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    inverse = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    reset_n = 1'b1;
    step();
    chk_all_zero("idle");

    run_seq("fwd", 1'b0, 1'b0);
    run_seq("inv_inject", 1'b1, 1'b1);
    run_seq("b2b_fwd", 1'b0, 1'b0);

    start = 1'b1;
    inverse = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("midrst pre ang_valid", 32'(ang_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < LAT + 8; i++) begin
      chk($sformatf("postrst %0d tw_valid", i), 32'(tw_valid), 32'd0);
      chk($sformatf("postrst %0d done", i),     32'(done),     32'd0);
      chk($sformatf("postrst %0d busy", i),     32'(busy),     32'd0);
      step();
    end
    run_seq("postrst_fwd", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
